// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : control FSM encoding (IDLE -> SHIFT -> DONE -> IDLE)
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: computes a - b - bin for a single bit position.
// Ports:
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b beats a outright, or when the bits tie and a borrow arrives.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: {bo,d} = a - b - bi, one bit per clock, LSB first.
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready; an output transfer happens on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE and out_valid only in
// DONE, so accept and consume can never share an edge.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake
//   a, b, bi            : minuend, subtrahend, borrow in (sampled on accept only)
//   out_valid, out_ready: result handshake
//   d, bo               : difference and borrow out (hold last completed result)
module serial_sub4
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  full_sub_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (state == SHIFT) && (cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // The minuend register doubles as the result shift register: each SHIFT
  // cycle consumes a_sh[0] and inserts the new difference bit at the MSB, so
  // after WIDTH steps it holds the full difference. d/bo are separate output
  // registers written only when the last bit completes, so they keep the
  // previous result throughout the next operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bo   <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bi;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= {cell_d, a_sh[WIDTH-1:1]};
      b_sh <= b_sh >> 1;
      br   <= cell_bout;
      cnt  <= cnt + CNT_W'(1);
      if (last_bit) begin
        d  <= {cell_d, a_sh[WIDTH-1:1]};
        bo <= cell_bout;
      end
    end
  end

endmodule

// File: doc/serial_sub4.md
SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: bi  input  1  borrow in.
REQ-009 SHALL have port: out_valid  output  1  result held on d/bo.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: d  output  WIDTH  difference.
REQ-012 SHALL have port: bo  output  1  borrow out.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept operands only on an edge where in_valid && in_ready: capture a, b into shift registers, bi into the borrow register, clear bit counter, go to SHIFT.
REQ-015 SHALL NOT sample a, b, bi at any other time; in_valid outside IDLE has no effect.
REQ-016 SHALL, each SHIFT cycle, process the LSB: diff = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br); shift diff into the result MSB; shift a, b right one; increment counter.
REQ-017 SHALL leave SHIFT for DONE on the edge that processes bit WIDTH-1; out_valid rises exactly WIDTH edges after the accepting edge.
REQ-018 SHALL produce {bo,d} = (a - b - bi) mod 2^(WIDTH+1); bo=1 iff a < b+bi.
REQ-019 SHALL hold d, bo, out_valid stable in DONE until an edge with out_ready=1, then go to IDLE (out_valid=0, in_ready=1 next cycle).
REQ-020 SHALL NOT accept new operands in the same cycle a result is consumed; minimum period WIDTH+2 cycles per operation with out_ready tied high.
REQ-021 SHALL keep d and bo at the last completed result while in IDLE and SHIFT; the SHIFT datapath uses internal registers only.

Reset
REQ-022 SHALL, on any edge with rst_n=0, set state=IDLE, d=0, bo=0, counter=0, shift and borrow registers=0; hence out_valid=0, in_ready=1.
REQ-023 SHALL discard an in-flight operation on reset mid-SHIFT or mid-DONE; no result is emitted for it.
REQ-024 SHALL give rst_n priority over in_valid and out_ready on the same edge.

Structure
REQ-025 SHALL place the FSM state enum and default WIDTH constant in a shared package, serial_sub_pkg.
REQ-026 SHALL instantiate one combinational sub-module, full_sub_cell (inputs a, b, bin; outputs d, bout), for the per-bit step.
REQ-027 SHALL size the counter to $clog2(WIDTH) bits and contain no latches or combinational loops.

Verification
REQ-028 SHALL cover: a=9, b=3, bi=0 -> d=6, bo=0, out_valid high exactly 4 edges after the accepting edge.
REQ-029 SHALL cover: a=3, b=9, bi=0 -> d=4'hA, bo=1; a=0, b=0, bi=1 -> d=4'hF, bo=1; a=4'hF, b=4'hF, bi=1 -> d=4'hF, bo=1.
REQ-030 SHALL cover: out_ready low 5 cycles in DONE with in_valid=1 and changing a/b -> d, bo, out_valid unchanged, in_ready=0, no accept.
REQ-031 SHALL cover: rst_n=0 for one edge when counter=2 -> next cycle out_valid=0, d=0, bo=0, in_ready=1, no result ever emitted for that operation.
REQ-032 SHALL cover: all 512 (a,b,bi) combinations back-to-back, out_ready=1 -> every result matches the model (a-b-bi), one operation per 6 cycles.
